// File: rtl/fpadd_arbiter_if.sv
// fpadd_arbiter_if: requester and adder-side signals of the shared fp16 adder arbiter
interface fpadd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FP_W = 16
);
  logic [NUM_REQ-1:0] req_valid, req_ready, resp_valid;
  logic [NUM_REQ*FP_W-1:0] req_a, req_b;
  logic [FP_W-1:0] add_a, add_b, add_out, resp_out;
  logic add_overflow, add_sub, resp_overflow, resp_sub;
  modport master (
    output req_valid, req_a, req_b, add_out, add_overflow, add_sub,
    input req_ready, add_a, add_b, resp_valid, resp_out, resp_overflow, resp_sub
  );
  modport slave (
    input req_valid, req_a, req_b, add_out, add_overflow, add_sub,
    output req_ready, add_a, add_b, resp_valid, resp_out, resp_overflow, resp_sub
  );
endinterface

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: round-robin sharing of one pipelined fp16 adder; FPADD_ARB_STATS_EN adds issue/overflow counters
module fpadd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PIPE_LAT = 2,
  parameter int FP_W = 16
) (
  input logic CLK,
  input logic RST,
  fpadd_arbiter_if.slave bus
`ifdef FPADD_ARB_STATS_EN
  ,
  output logic [15:0] stat_issue,
  output logic [15:0] stat_ovf
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, gnt_id, idx;
  logic gnt_any;
  logic [PIPE_LAT:0] tag_v;
  logic [IW-1:0] tag_id [PIPE_LAT+1];
  // rotating priority search that starts at the round-robin pointer
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign bus.req_ready = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
  // issue stage: capture the granted operands and step the pointer past the winner
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      bus.add_a <= '0;
      bus.add_b <= '0;
      ptr <= '0;
    end else if (gnt_any) begin
      bus.add_a <= bus.req_a[gnt_id*FP_W +: FP_W];
      bus.add_b <= bus.req_b[gnt_id*FP_W +: FP_W];
      ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  // tag shift register: stage 0 sits beside add_a/add_b, stage PIPE_LAT lines up with add_out
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      tag_v <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v <= {tag_v[PIPE_LAT-1:0], gnt_any};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  // steer the aligned adder result back to its requester as a one-cycle pulse
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      bus.resp_valid <= '0;
      bus.resp_out <= '0;
      bus.resp_overflow <= 1'b0;
      bus.resp_sub <= 1'b0;
    end else begin
      bus.resp_valid <= tag_v[PIPE_LAT] ? NUM_REQ'(1) << tag_id[PIPE_LAT] : '0;
      if (tag_v[PIPE_LAT]) begin
        bus.resp_out <= bus.add_out;
        bus.resp_overflow <= bus.add_overflow;
        bus.resp_sub <= bus.add_sub;
      end
    end
`ifdef FPADD_ARB_STATS_EN
  // saturating counts of accepted ops and of overflowing response pulses
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      stat_issue <= '0;
      stat_ovf <= '0;
    end else begin
      if (gnt_any && stat_issue != 16'hFFFF) stat_issue <= stat_issue + 1'b1;
      if (|bus.resp_valid && bus.resp_overflow && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed checks of arbitration, tag steering and reset for fpadd_arbiter
module tb_fpadd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int PIPE_LAT = 2;
  localparam int FP_W = 16;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] pipe [PIPE_LAT];
  logic [15:0] sums [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h4800};
  fpadd_arbiter_if #(.NUM_REQ(NUM_REQ), .FP_W(FP_W)) bus ();
`ifdef FPADD_ARB_STATS_EN
  logic [15:0] stat_issue, stat_ovf;
`endif
  fpadd_arbiter #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT), .FP_W(FP_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef FPADD_ARB_STATS_EN
    ,
    .stat_issue(stat_issue),
    .stat_ovf(stat_ovf)
`endif
  );
  always #5 CLK = ~CLK;
  // adder stand-in: hand-computed table of the directed vectors, {overflow, sub, sum}
  function automatic logic [17:0] fp_model(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C003C00: return {2'b00, 16'h4000};
      32'h3C004000: return {2'b00, 16'h4200};
      32'h40004000: return {2'b00, 16'h4400};
      32'h44004400: return {2'b00, 16'h4800};
      32'h4000C000: return {2'b01, 16'h0000};
      32'h7BFF7BFF: return {2'b10, 16'h7C00};
      default: return {2'b00, 16'hDEAD};
    endcase
  endfunction
  always @(posedge CLK) begin
    pipe[0] <= fp_model(bus.add_a, bus.add_b);
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_out = pipe[PIPE_LAT-1][15:0];
  assign bus.add_sub = pipe[PIPE_LAT-1][16];
  assign bus.add_overflow = pipe[PIPE_LAT-1][17];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[id*FP_W +: FP_W] = a;
    bus.req_b[id*FP_W +: FP_W] = b;
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  // single op from one requester: grant, operand capture, PIPE_LAT+1 latency, pulse and hold
  task automatic issue(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] sum, input logic ovf, input logic sub);
    set_op(id, a, b);
    bus.req_valid = NUM_REQ'(1) << id;
    #1 chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << id);
    tick();
    bus.req_valid = '0;
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'(a));
    chk({tag, "_add_b"}, 32'(bus.add_b), 32'(b));
    repeat (2) begin
      tick();
      chk({tag, "_early"}, 32'(bus.resp_valid), 32'(0));
    end
    tick();
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'(1) << id);
    chk({tag, "_out"}, 32'(bus.resp_out), 32'(sum));
    chk({tag, "_ovf"}, 32'(bus.resp_overflow), 32'(ovf));
    chk({tag, "_sub"}, 32'(bus.resp_sub), 32'(sub));
    tick();
    chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'(0));
    chk({tag, "_hold"}, 32'(bus.resp_out), 32'(sum));
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_add_a", 32'(bus.add_a), 32'(0));
    chk("rst_valid", 32'(bus.resp_valid), 32'(0));
    chk("rst_out", 32'(bus.resp_out), 32'(0));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    tick();
    issue("single", 0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    issue("cancel", 2, 16'h4000, 16'hC000, 16'h0000, 1'b0, 1'b1);
    issue("ovf", 3, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0);
`ifdef FPADD_ARB_STATS_EN
    chk("stat_issue_3", 32'(stat_issue), 32'(3));
    chk("stat_ovf_1", 32'(stat_ovf), 32'(1));
`endif
    set_op(0, 16'h3C00, 16'h3C00);
    set_op(1, 16'h3C00, 16'h4000);
    set_op(2, 16'h4000, 16'h4000);
    set_op(3, 16'h4400, 16'h4400);
    for (int k = 0; k < 12; k++) begin
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      chk("rot_ready", 32'(bus.req_ready), (k < 8) ? 32'(1) << (k % 4) : 32'(0));
      if (k < 4) chk("rot_idle", 32'(bus.resp_valid), 32'(0));
      else begin
        chk("rot_valid", 32'(bus.resp_valid), 32'(1) << ((k - 4) % 4));
        chk("rot_out", 32'(bus.resp_out), 32'(sums[(k - 4) % 4]));
        chk("rot_ovf", 32'(bus.resp_overflow), 32'(0));
      end
      tick();
    end
`ifdef FPADD_ARB_STATS_EN
    chk("stat_issue_11", 32'(stat_issue), 32'(11));
    chk("stat_ovf_keep", 32'(stat_ovf), 32'(1));
`endif
    bus.req_valid = 4'hF;
    tick();
    tick();
    bus.req_valid = '0;
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'(0));
    chk("mid_rst_add_a", 32'(bus.add_a), 32'(0));
    chk("mid_rst_out", 32'(bus.resp_out), 32'(0));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
`ifdef FPADD_ARB_STATS_EN
    chk("stat_issue_clr", 32'(stat_issue), 32'(0));
    chk("stat_ovf_clr", 32'(stat_ovf), 32'(0));
`endif
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("dropped", 32'(bus.resp_valid), 32'(0));
    end
    bus.req_valid = 4'b1001;
    #1 chk("rr_restart", 32'(bus.req_ready), 32'(1));
    tick();
    bus.req_valid = 4'b0010;
    #1 chk("int_r1", 32'(bus.req_ready), 32'(2));
    tick();
    bus.req_valid = 4'b0000;
    #1 chk("int_none", 32'(bus.req_ready), 32'(0));
    tick();
    bus.req_valid = 4'b0011;
    #1 chk("int_r0", 32'(bus.req_ready), 32'(1));
    tick();
    bus.req_valid = '0;
    chk("int_resp0_v", 32'(bus.resp_valid), 32'(1));
    chk("int_resp0_o", 32'(bus.resp_out), 32'(16'h4000));
    tick();
    chk("int_resp1_v", 32'(bus.resp_valid), 32'(2));
    chk("int_resp1_o", 32'(bus.resp_out), 32'(16'h4200));
    tick();
    chk("int_gap_v", 32'(bus.resp_valid), 32'(0));
    chk("int_gap_o", 32'(bus.resp_out), 32'(16'h4200));
    tick();
    chk("int_resp2_v", 32'(bus.resp_valid), 32'(1));
    chk("int_resp2_o", 32'(bus.resp_out), 32'(16'h4000));
`ifdef FPADD_ARB_STATS_EN
    chk("stat_issue_3b", 32'(stat_issue), 32'(3));
    chk("stat_ovf_0", 32'(stat_ovf), 32'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
